sync_fifo_occ: RTL

Parametrised synchronous FIFO that reports its own occupancy, programmable watermarks, peak occupancy and sticky overflow/underflow error flags. It is the next-generation FIFO whose `number_of_current_entries` output feeds the team's FIFO coverage checker. It generalises the fixed 6-entry, 3-bit-count FIFO to any depth, including non-power-of-two depths, and any data width. It sits between a single producer and a single consumer in one clock domain.

---
 rtl/sync_fifo_occ.sv | 104 ++++++++++
 1 files changed

// File: rtl/sync_fifo_occ.sv
// Synchronous single-clock FIFO for any depth (power of two or not).
// Reports occupancy, watermarks, peak occupancy and sticky overflow/underflow flags.
module sync_fifo_occ #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 6,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1,
    parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] number_of_current_entries,
    output logic [CNT_W-1:0] peak_entries,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             rd_acc;
    logic             wr_acc;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] peak_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;

    // Accept decisions come from registered flags; a full FIFO may take a write only alongside a pop.
    always_comb begin
        rd_acc   = rd_en & ~empty;
        wr_acc   = wr_en & (~full | rd_acc);
        cnt_nxt  = number_of_current_entries;
        if (wr_acc && !rd_acc) begin
            cnt_nxt = number_of_current_entries + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            cnt_nxt = number_of_current_entries - CNT_W'(1);
        end
        ovf_nxt  = (overflow  & ~clr_err) | (wr_en & ~wr_acc);
        unf_nxt  = (underflow & ~clr_err) | (rd_en & ~rd_acc);
        peak_nxt = peak_entries;
        if (clr_err || (cnt_nxt > peak_entries)) begin
            peak_nxt = cnt_nxt;
        end
    end

    // Storage is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr                    <= '0;
            rd_ptr                    <= '0;
            rd_data                   <= '0;
            rd_valid                  <= 1'b0;
            number_of_current_entries <= '0;
            full                      <= 1'b0;
            empty                     <= 1'b1;
            almost_full               <= (AF_LEVEL == 0);
            almost_empty              <= 1'b1;
            peak_entries              <= '0;
            overflow                  <= 1'b0;
            underflow                 <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_acc;

            // Status flags decode the next occupancy so they line up with the count.
            number_of_current_entries <= cnt_nxt;
            full                      <= (cnt_nxt == CNT_MAX);
            empty                     <= (cnt_nxt == '0);
            almost_full               <= (32'(cnt_nxt) >= AF_LEVEL);
            almost_empty              <= (32'(cnt_nxt) <= AE_LEVEL);
            peak_entries              <= peak_nxt;
            overflow                  <= ovf_nxt;
            underflow                 <= unf_nxt;
        end
    end

endmodule
